// File: rtl/maze_map_loader.sv
// maze_map_loader: streams an 8x8 maze map into SRAM, validates cells and
// terminal indices, appends an 0xFF end-of-list marker, then pulses start.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load                request a new map load (honoured in IDLE/DONE)
//   s_valid/s_ready     byte stream handshake; s_data byte, s_last final byte
//   address, data_out   SRAM write address / data (registered)
//   cs, we              SRAM chip select / write enable (registered)
//   start               one-cycle pulse once the map is fully written
//   busy                loader active (GRID, TERM, SENTINEL, START)
//   err                 0 none, 1 illegal cell, 2 short stream, 3 bad terminal
module maze_map_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_GRID = 64,
  parameter int MAX_TERMINAL = 64,
  parameter logic [ADDR_WIDTH-1:0] TERM_BASE = 8'h80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  cs,
  output logic                  we,
  output logic                  start,
  output logic                  busy,
  output logic [1:0]            err
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRID, S_TERM, S_SENT,
    S_START, S_DONE, S_ERROR
  } state_t;

  localparam logic [6:0] LAST_CELL = 7'(MAX_GRID - 1);
  localparam logic [6:0] TERM_FULL = 7'(MAX_TERMINAL);
  localparam logic [DATA_WIDTH-1:0] C_FREE = DATA_WIDTH'(8'h00);
  localparam logic [DATA_WIDTH-1:0] C_OBST = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] C_TERM = DATA_WIDTH'(8'hEE);

  state_t                r_state, w_state_nx;
  logic [6:0]            r_cell, w_cell_nx;
  logic [6:0]            r_term, w_term_nx;
  logic [MAX_GRID-1:0]   r_mask, w_mask_nx;
  logic [1:0]            r_err, w_err_nx;
  logic                  r_wr, w_wr;
  logic [ADDR_WIDTH-1:0] r_addr, w_wr_addr;
  logic [DATA_WIDTH-1:0] r_data, w_wr_data;

  logic       w_hs;
  logic       w_cell_ok;
  logic       w_idx_ok;
  logic [5:0] w_idx;

  assign s_ready = (r_state == S_GRID) || (r_state == S_TERM);
  assign busy = s_ready || (r_state == S_SENT) ||
                (r_state == S_START);
  assign start = (r_state == S_START);
  assign address = r_addr;
  assign data_out = r_data;
  assign cs = r_wr;
  assign we = r_wr;
  assign err = r_err;

  assign w_hs = s_valid && s_ready;
  assign w_cell_ok = (s_data == C_FREE) || (s_data == C_OBST) ||
                     (s_data == C_TERM);
  assign w_idx_ok = (s_data < DATA_WIDTH'(MAX_GRID));
  assign w_idx = s_data[5:0];

  always_comb begin
    w_state_nx = r_state;
    w_cell_nx = r_cell;
    w_term_nx = r_term;
    w_mask_nx = r_mask;
    w_err_nx = r_err;
    w_wr = 1'b0;
    w_wr_addr = r_addr;
    w_wr_data = r_data;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (load) begin
          w_state_nx = S_GRID;
          w_cell_nx = '0;
          w_term_nx = '0;
          w_mask_nx = '0;
          w_err_nx = 2'd0;
        end
      end
      S_GRID: begin
        if (w_hs) begin
          w_cell_nx = r_cell + 7'd1;
          if (!w_cell_ok) begin
            w_state_nx = S_ERROR;
            w_err_nx = 2'd1;
          end else if (s_last) begin
            // the stream must continue into the terminal list
            w_state_nx = S_ERROR;
            w_err_nx = 2'd2;
          end else begin
            w_wr = 1'b1;
            w_wr_addr = ADDR_WIDTH'(r_cell);
            w_wr_data = s_data;
            if (s_data == C_TERM) w_mask_nx[r_cell[5:0]] = 1'b1;
            if (r_cell == LAST_CELL) w_state_nx = S_TERM;
          end
        end
      end
      S_TERM: begin
        if (w_hs) begin
          if (r_term == TERM_FULL || !w_idx_ok || !r_mask[w_idx]) begin
            w_state_nx = S_ERROR;
            w_err_nx = 2'd3;
          end else if (s_last && r_term == 7'd0) begin
            // a route needs at least two terminals
            w_state_nx = S_ERROR;
            w_err_nx = 2'd2;
          end else begin
            w_wr = 1'b1;
            w_wr_addr = TERM_BASE + ADDR_WIDTH'(r_term);
            w_wr_data = s_data;
            // clearing the bit makes a repeated index illegal
            w_mask_nx[w_idx] = 1'b0;
            w_term_nx = r_term + 7'd1;
            if (s_last) w_state_nx = S_SENT;
          end
        end
      end
      S_SENT: begin
        w_wr = 1'b1;
        w_wr_addr = TERM_BASE + ADDR_WIDTH'(r_term);
        w_wr_data = C_OBST;
        w_state_nx = S_START;
      end
      S_START: w_state_nx = S_DONE;
      S_ERROR: w_state_nx = S_ERROR;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cell <= '0;
      r_term <= '0;
      r_mask <= '0;
      r_err <= 2'd0;
      r_wr <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cell <= w_cell_nx;
      r_term <= w_term_nx;
      r_mask <= w_mask_nx;
      r_err <= w_err_nx;
      r_wr <= w_wr;
      r_addr <= w_wr_addr;
      r_data <= w_wr_data;
    end
  end

endmodule

// File: doc/maze_map_loader.md
MAZE_MAP_LOADER -- requirements
Module: maze_map_loader

Interface
REQ-001 Parameters: DATA_WIDTH=8 (SRAM data width); ADDR_WIDTH=8 (SRAM address width); MAX_GRID=64 (grid cells, 8x8); MAX_TERMINAL=64 (terminal list capacity); TERM_BASE=8'h80 (terminal list base address).
REQ-002 clk  in  1  clock; only clock, all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load  in  1  one-cycle request to begin a new map load; sampled in IDLE and DONE only.
REQ-005 s_valid  in  1  map byte valid.
REQ-006 s_data  in  8  map byte.
REQ-007 s_last  in  1  marks final byte of map stream.
REQ-008 s_ready  out  1  loader accepts byte; transfer occurs when s_valid and s_ready are both high.
REQ-009 address  out  8  SRAM address.
REQ-010 data_out  out  8  SRAM write data.
REQ-011 cs  out  1  SRAM chip select.
REQ-012 we  out  1  SRAM write enable.
REQ-013 start  out  1  one-cycle pulse to router after a valid map is fully written.
REQ-014 busy  out  1  high in GRID, TERM, SENTINEL and START states.
REQ-015 err  out  2  00 none, 01 illegal cell value, 02 short stream or too few terminals, 03 bad or overflowing terminal index.

Function
REQ-016 States: IDLE, GRID, TERM, SENTINEL, START, DONE, ERROR.
REQ-017 IDLE/DONE + load -> GRID; clear cell counter, terminal counter, 64-bit terminal mask, err.
REQ-018 s_ready = 1 only in GRID and TERM; combinational from state.
REQ-019 GRID: k-th accepted byte (k=0..63) is a cell; legal values 8'h00 free, 8'hFF obstacle, 8'hEE terminal; 8'hEE sets mask[k].
REQ-020 Legal accepted byte at handshake cycle N -> cycle N+1: cs=1, we=1, address=k (grid) or TERM_BASE+j (terminal), data_out=byte; otherwise cs=we=0.
REQ-021 After the 64th cell -> TERM; s_last on the 64th cell is an error (err=02).
REQ-022 s_last on any cell before the 64th -> ERROR, err=02.
REQ-023 TERM: accepted byte is terminal index j; legal iff byte < 64 and mask[byte]=1; on accept clear mask[byte] (duplicates illegal) and increment j.
REQ-024 Illegal terminal byte, or j already 64 -> ERROR, err=03.
REQ-025 Legal terminal byte with s_last: if final j >= 2 -> SENTINEL, else ERROR, err=02.
REQ-026 SENTINEL: one cycle of cs=we=1, address=TERM_BASE+j, data_out=8'hFF (end-of-list marker); then START.
REQ-027 START: start=1 for exactly one cycle, then DONE.
REQ-028 Offending byte is consumed (handshake completes) but never written to SRAM; err priority 01 over 02 over 03 not needed, each byte yields at most one error.
REQ-029 ERROR: s_ready=0, cs=we=start=0, err held; exits only via reset.
REQ-030 Cell counter 7 bits, terminal counter 7 bits; no wrap: 64 is terminal state of count.
REQ-031 Unlisted 8'hEE cells are permitted (router resolves them); no check on unused terminals.
REQ-032 load outside IDLE/DONE ignored; s_valid outside GRID/TERM ignored.

Reset
REQ-033 Reset (any state, incl. mid-load) -> IDLE next edge; address=0, data_out=0, cs=0, we=0, start=0, s_ready=0, busy=0, err=00; counters and mask cleared; pending registered write discarded.

Verification
REQ-034 Load 64 cells all 00 except cells 3,60 = EE, terminals 3,60 with s_last -> writes 0..63, 0x80=03, 0x81=3C, 0x82=FF, one start pulse, DONE, err=00.
REQ-035 Cell 10 = 8'h55 -> ERROR, err=01, no write to address 10, s_ready low thereafter.
REQ-036 s_last on cell 40 -> ERROR, err=02; single terminal with s_last -> ERROR, err=02, no sentinel.
REQ-037 Terminal index 64, or terminal 5 where cell 5=00, or terminal 3 listed twice -> ERROR, err=03.
REQ-038 s_valid toggled randomly with back-to-back and gapped bytes -> write sequence identical to REQ-034; each write exactly one cycle after its handshake.
REQ-039 Reset asserted mid-GRID at cell 20 -> IDLE, all outputs at reset values; new load completes normally.
